// File: rtl/axi_sram_slave.sv
// axi_sram_slave
//   AXI4 responder modelling an on-chip SRAM. It serves INCR read and write
//   bursts from a byte-addressable word array. Read and write channels are
//   independent FSMs, so one read and one write can be in flight together.
//   The first R beat appears RD_LATENCY cycles after the AR handshake.
//
// Ports
//   clock, reset                 clock and synchronous active-high reset
//   axi_addr_r_*                 AR channel: addr, len, size, valid/ready
//   axi_r_*                      R channel: data, resp, last, valid/ready
//   axi_addr_w_*                 AW channel: addr, len, size, valid/ready
//   axi_w_*                      W channel: data, strb, last, valid/ready
//   axi_bkwd_*                   B channel: resp, valid/ready
module axi_sram_slave #(
  parameter int unsigned          ADDR_LEN   = 32,
  parameter int unsigned          DATA_LEN   = 32,
  parameter int unsigned          MEM_WORDS  = 1024,
  parameter logic [ADDR_LEN-1:0]  BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned          RD_LATENCY = 2
) (
  input  logic                clock,
  input  logic                reset,
  // AR channel
  input  logic [ADDR_LEN-1:0] axi_addr_r_addr_i,
  input  logic                axi_addr_r_valid_i,
  output logic                axi_addr_r_ready_o,
  input  logic [7:0]          axi_addr_r_len_i,
  input  logic [2:0]          axi_addr_r_size_i,
  // R channel
  output logic [DATA_LEN-1:0] axi_r_data_o,
  output logic [1:0]          axi_r_resp_o,
  output logic                axi_r_valid_o,
  output logic                axi_r_last_o,
  input  logic                axi_r_ready_i,
  // AW channel
  input  logic [ADDR_LEN-1:0] axi_addr_w_addr_i,
  input  logic                axi_addr_w_valid_i,
  output logic                axi_addr_w_ready_o,
  input  logic [7:0]          axi_addr_w_len_i,
  input  logic [2:0]          axi_addr_w_size_i,
  // W channel
  input  logic [DATA_LEN-1:0] axi_w_data_i,
  input  logic [3:0]          axi_w_strb_i,
  input  logic                axi_w_valid_i,
  output logic                axi_w_ready_o,
  input  logic                axi_w_last_i,
  // B channel
  output logic [1:0]          axi_bkwd_resp_o,
  output logic                axi_bkwd_valid_o,
  input  logic                axi_bkwd_ready_i
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned DLY_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_LEN-1:0] MEM_BYTES = ADDR_LEN'(4 * MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_LEN-1:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [ADDR_LEN-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < MEM_BYTES);
  endfunction

  // Byte lane is dropped: a full word is always accessed.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_LEN-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  // ---------------------------------------------------------------- read
  r_state_t            r_state, r_next;
  logic [ADDR_LEN-1:0] r_addr;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [7:0]          r_beat;
  logic [DLY_W-1:0]    r_dly;
  logic [DATA_LEN-1:0] r_data_q;
  logic [1:0]          r_resp_q;
  logic                r_valid_q;
  logic                r_last_q;

  logic                ar_hs, r_hs, load_beat;
  logic [ADDR_LEN-1:0] rd_next_addr, rd_addr;
  logic                rd_ok;
  logic [DATA_LEN-1:0] rd_word;
  logic [7:0]          load_beat_num;

  assign axi_addr_r_ready_o = (r_state == R_IDLE) && !reset;
  assign axi_r_data_o       = r_data_q;
  assign axi_r_resp_o       = r_resp_q;
  assign axi_r_valid_o      = r_valid_q;
  assign axi_r_last_o       = r_last_q;

  assign ar_hs = axi_addr_r_valid_i && axi_addr_r_ready_o;
  assign r_hs  = r_valid_q && axi_r_ready_i;

  assign rd_next_addr = r_addr + (ADDR_LEN'(1) << r_size);
  // In R_DATA the beat being loaded is the one after the current handshake,
  // so the lookup uses the advanced address to avoid a bubble.
  assign rd_addr       = (r_state == R_DATA) ? rd_next_addr : r_addr;
  assign rd_ok         = in_range(rd_addr);
  assign rd_word       = rd_ok ? mem[word_idx(rd_addr)] : '0;
  assign load_beat_num = (r_state == R_DATA) ? 8'(r_beat + 8'd1) : r_beat;

  always_comb begin
    r_next    = r_state;
    load_beat = 1'b0;
    case (r_state)
      R_IDLE: if (ar_hs) r_next = R_WAIT;
      R_WAIT: begin
        if (r_dly == '0) begin
          load_beat = 1'b1;
          r_next    = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (r_last_q) r_next    = R_IDLE;
          else          load_beat = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_beat    <= '0;
      r_dly     <= '0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_addr <= axi_addr_r_addr_i;
            r_len  <= axi_addr_r_len_i;
            r_size <= axi_addr_r_size_i;
            r_beat <= '0;
            r_dly  <= DLY_W'(RD_LATENCY - 1);
          end
        end
        R_WAIT: if (r_dly != '0) r_dly <= r_dly - 1'b1;
        R_DATA: begin
          if (r_hs) begin
            r_beat <= 8'(r_beat + 8'd1);
            r_addr <= rd_next_addr;
            if (r_last_q) begin
              r_valid_q <= 1'b0;
              r_last_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
      // Array is sampled before any same-edge write lands: old data wins.
      if (load_beat) begin
        r_data_q  <= rd_word;
        r_resp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        r_valid_q <= 1'b1;
        r_last_q  <= (load_beat_num == r_len);
      end
    end
  end

  // --------------------------------------------------------------- write
  w_state_t            w_state, w_next;
  logic [ADDR_LEN-1:0] w_addr;
  logic [2:0]          w_size;
  logic                w_err;
  logic                aw_hs, w_hs, wr_ok;

  assign axi_addr_w_ready_o = (w_state == W_IDLE) && !reset;
  assign axi_w_ready_o      = (w_state == W_DATA);
  assign axi_bkwd_valid_o   = (w_state == W_RESP);
  assign axi_bkwd_resp_o    = ((w_state == W_RESP) && w_err) ? RESP_SLVERR : RESP_OKAY;

  assign aw_hs = axi_addr_w_valid_i && axi_addr_w_ready_o;
  assign w_hs  = axi_w_valid_i && axi_w_ready_o;
  assign wr_ok = in_range(w_addr);

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && axi_w_last_i) w_next = W_RESP;
      W_RESP:  if (axi_bkwd_ready_i) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_addr <= '0;
      w_size <= '0;
      w_err  <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_addr <= axi_addr_w_addr_i;
        w_size <= axi_addr_w_size_i;
        w_err  <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= w_addr + (ADDR_LEN'(1) << w_size);
        if (!wr_ok) w_err <= 1'b1;
      end
    end
  end

  // Memory has no reset; contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (!reset && w_hs && wr_ok) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (axi_w_strb_i[b]) mem[word_idx(w_addr)][8*b +: 8] <= axi_w_data_i[8*b +: 8];
      end
    end
  end

  // Burst length on the write side is intentionally not checked.
  logic unused_w_len;
  assign unused_w_len = ^axi_addr_w_len_i;

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] axi_addr_r_addr_i;
  logic        axi_addr_r_valid_i;
  logic        axi_addr_r_ready_o;
  logic [7:0]  axi_addr_r_len_i;
  logic [2:0]  axi_addr_r_size_i;
  logic [31:0] axi_r_data_o;
  logic [1:0]  axi_r_resp_o;
  logic        axi_r_valid_o;
  logic        axi_r_last_o;
  logic        axi_r_ready_i;
  logic [31:0] axi_addr_w_addr_i;
  logic        axi_addr_w_valid_i;
  logic        axi_addr_w_ready_o;
  logic [7:0]  axi_addr_w_len_i;
  logic [2:0]  axi_addr_w_size_i;
  logic [31:0] axi_w_data_i;
  logic [3:0]  axi_w_strb_i;
  logic        axi_w_valid_i;
  logic        axi_w_ready_o;
  logic        axi_w_last_i;
  logic [1:0]  axi_bkwd_resp_o;
  logic        axi_bkwd_valid_o;
  logic        axi_bkwd_ready_i;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  axi_sram_slave #(
    .ADDR_LEN(32), .DATA_LEN(32), .MEM_WORDS(1024),
    .BASE_ADDR(32'h8000_0000), .RD_LATENCY(2)
  ) dut (
    .clock(clock), .reset(reset),
    .axi_addr_r_addr_i(axi_addr_r_addr_i), .axi_addr_r_valid_i(axi_addr_r_valid_i),
    .axi_addr_r_ready_o(axi_addr_r_ready_o), .axi_addr_r_len_i(axi_addr_r_len_i),
    .axi_addr_r_size_i(axi_addr_r_size_i),
    .axi_r_data_o(axi_r_data_o), .axi_r_resp_o(axi_r_resp_o), .axi_r_valid_o(axi_r_valid_o),
    .axi_r_last_o(axi_r_last_o), .axi_r_ready_i(axi_r_ready_i),
    .axi_addr_w_addr_i(axi_addr_w_addr_i), .axi_addr_w_valid_i(axi_addr_w_valid_i),
    .axi_addr_w_ready_o(axi_addr_w_ready_o), .axi_addr_w_len_i(axi_addr_w_len_i),
    .axi_addr_w_size_i(axi_addr_w_size_i),
    .axi_w_data_i(axi_w_data_i), .axi_w_strb_i(axi_w_strb_i), .axi_w_valid_i(axi_w_valid_i),
    .axi_w_ready_o(axi_w_ready_o), .axi_w_last_i(axi_w_last_i),
    .axi_bkwd_resp_o(axi_bkwd_resp_o), .axi_bkwd_valid_o(axi_bkwd_valid_o),
    .axi_bkwd_ready_i(axi_bkwd_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a negedge.
  task automatic ar_req(input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    axi_addr_r_addr_i  = a;
    axi_addr_r_len_i   = len;
    axi_addr_r_size_i  = 3'd2;
    axi_addr_r_valid_i = 1'b1;
    while (!axi_addr_r_ready_o && n < 50) begin @(negedge clock); n++; end
    check("ar_accept", {31'd0, axi_addr_r_ready_o}, 32'd1);
    @(negedge clock);
    axi_addr_r_valid_i = 1'b0;
  endtask

  task automatic aw_req(input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    axi_addr_w_addr_i  = a;
    axi_addr_w_len_i   = len;
    axi_addr_w_size_i  = 3'd2;
    axi_addr_w_valid_i = 1'b1;
    while (!axi_addr_w_ready_o && n < 50) begin @(negedge clock); n++; end
    check("aw_accept", {31'd0, axi_addr_w_ready_o}, 32'd1);
    @(negedge clock);
    axi_addr_w_valid_i = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    axi_w_data_i  = d;
    axi_w_strb_i  = s;
    axi_w_last_i  = l;
    axi_w_valid_i = 1'b1;
    while (!axi_w_ready_o && n < 50) begin @(negedge clock); n++; end
    check("w_accept", {31'd0, axi_w_ready_o}, 32'd1);
    @(negedge clock);
    axi_w_valid_i = 1'b0;
    axi_w_last_i  = 1'b0;
  endtask

  task automatic b_check(input logic [1:0] exp_resp, input int hold);
    int n = 0;
    while (!axi_bkwd_valid_o && n < 50) begin @(negedge clock); n++; end
    check("b_valid", {31'd0, axi_bkwd_valid_o}, 32'd1);
    check("b_resp", {30'd0, axi_bkwd_resp_o}, {30'd0, exp_resp});
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check("b_held", {31'd0, axi_bkwd_valid_o}, 32'd1);
    end
    axi_bkwd_ready_i = 1'b1;
    @(negedge clock);
    axi_bkwd_ready_i = 1'b0;
    check("b_done", {31'd0, axi_bkwd_valid_o}, 32'd0);
    check("aw_ready_after_b", {31'd0, axi_addr_w_ready_o}, 32'd1);
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!axi_r_valid_o && n < 50) begin @(negedge clock); n++; end
    check("r_valid_wait", {31'd0, axi_r_valid_o}, 32'd1);
  endtask

  task automatic rd_single(input string tag, input logic [31:0] a,
                           input logic [31:0] exp_d, input logic [1:0] exp_r);
    ar_req(a, 8'd0);
    wait_rvalid();
    check({tag, "_data"}, axi_r_data_o, exp_d);
    check({tag, "_resp"}, {30'd0, axi_r_resp_o}, {30'd0, exp_r});
    check({tag, "_last"}, {31'd0, axi_r_last_o}, 32'd1);
    axi_r_ready_i = 1'b1;
    @(negedge clock);
    axi_r_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    axi_addr_r_addr_i = '0; axi_addr_r_valid_i = 1'b0; axi_addr_r_len_i = '0; axi_addr_r_size_i = 3'd2;
    axi_r_ready_i = 1'b0;
    axi_addr_w_addr_i = '0; axi_addr_w_valid_i = 1'b0; axi_addr_w_len_i = '0; axi_addr_w_size_i = 3'd2;
    axi_w_data_i = '0; axi_w_strb_i = '0; axi_w_valid_i = 1'b0; axi_w_last_i = 1'b0;
    axi_bkwd_ready_i = 1'b0;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_ar_ready", {31'd0, axi_addr_r_ready_o}, 32'd0);
    check("rst_aw_ready", {31'd0, axi_addr_w_ready_o}, 32'd0);
    check("rst_w_ready",  {31'd0, axi_w_ready_o}, 32'd0);
    check("rst_r_valid",  {31'd0, axi_r_valid_o}, 32'd0);
    check("rst_r_last",   {31'd0, axi_r_last_o}, 32'd0);
    check("rst_r_resp",   {30'd0, axi_r_resp_o}, 32'd0);
    check("rst_b_valid",  {31'd0, axi_bkwd_valid_o}, 32'd0);
    check("rst_b_resp",   {30'd0, axi_bkwd_resp_o}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_ar_ready", {31'd0, axi_addr_r_ready_o}, 32'd1);
    check("idle_aw_ready", {31'd0, axi_addr_w_ready_o}, 32'd1);

    // Preload words 0..4 and word 9
    aw_req(32'h8000_0000, 8'd4);
    for (int i = 0; i < 5; i++)
      w_beat((i < 4) ? (32'hA000_0000 + 32'(i)) : 32'hDEAD_BEEF, 4'hF, i == 4);
    b_check(2'b00, 0);
    aw_req(32'h8000_0024, 8'd0);
    w_beat(32'h9988_7766, 4'hF, 1'b1);
    b_check(2'b00, 0);

    // Single read, latency 2
    ar_req(32'h8000_0010, 8'd0);
    check("lat_t1_r_valid", {31'd0, axi_r_valid_o}, 32'd0);
    @(negedge clock);
    check("lat_t1b_r_valid", {31'd0, axi_r_valid_o}, 32'd0);
    @(negedge clock);
    check("lat_t2_r_valid", {31'd0, axi_r_valid_o}, 32'd1);
    check("lat_t2_data", axi_r_data_o, 32'hDEAD_BEEF);
    check("lat_t2_last", {31'd0, axi_r_last_o}, 32'd1);
    check("lat_t2_resp", {30'd0, axi_r_resp_o}, 32'd0);
    axi_r_ready_i = 1'b1;
    @(negedge clock);
    axi_r_ready_i = 1'b0;
    check("single_done", {31'd0, axi_r_valid_o}, 32'd0);

    // 4-beat burst with stalls
    ar_req(32'h8000_0000, 8'd3);
    for (int i = 0; i < 4; i++) begin
      wait_rvalid();
      check("burst_data", axi_r_data_o, 32'hA000_0000 + 32'(i));
      check("burst_last", {31'd0, axi_r_last_o}, {31'd0, i == 3});
      @(negedge clock);
      check("burst_hold_valid", {31'd0, axi_r_valid_o}, 32'd1);
      check("burst_hold_data", axi_r_data_o, 32'hA000_0000 + 32'(i));
      check("burst_hold_last", {31'd0, axi_r_last_o}, {31'd0, i == 3});
      axi_r_ready_i = 1'b1;
      @(negedge clock);
      axi_r_ready_i = 1'b0;
    end
    check("burst_end_ar_ready", {31'd0, axi_addr_r_ready_o}, 32'd1);
    check("burst_end_r_valid", {31'd0, axi_r_valid_o}, 32'd0);

    // Write burst with partial strobe, then back-to-back read-back
    aw_req(32'h8000_0020, 8'd1);
    w_beat(32'h1122_3344, 4'hF, 1'b0);
    w_beat(32'hAABB_CCDD, 4'h3, 1'b1);
    b_check(2'b00, 0);
    axi_r_ready_i = 1'b1;
    ar_req(32'h8000_0020, 8'd1);
    wait_rvalid();
    check("wb_beat0", axi_r_data_o, 32'h1122_3344);
    check("wb_beat0_last", {31'd0, axi_r_last_o}, 32'd0);
    @(negedge clock);
    check("wb_beat1_valid", {31'd0, axi_r_valid_o}, 32'd1);
    check("wb_beat1", axi_r_data_o, 32'h9988_CCDD);
    check("wb_beat1_last", {31'd0, axi_r_last_o}, 32'd1);
    @(negedge clock);
    check("wb_done", {31'd0, axi_r_valid_o}, 32'd0);
    axi_r_ready_i = 1'b0;

    // Out-of-range read and write
    rd_single("oor_rd", 32'h7FFF_FFFC, 32'h0, 2'b10);
    aw_req(32'h9000_0000, 8'd0);
    w_beat(32'h1234_5678, 4'hF, 1'b1);
    b_check(2'b10, 0);
    rd_single("oor_w_mem0", 32'h8000_0000, 32'hA000_0000, 2'b00);

    // Concurrent AR and AW, B held for 5 cycles
    axi_addr_r_addr_i = 32'h8000_0010; axi_addr_r_len_i = 8'd0; axi_addr_r_valid_i = 1'b1;
    axi_addr_w_addr_i = 32'h8000_0028; axi_addr_w_len_i = 8'd0; axi_addr_w_valid_i = 1'b1;
    check("conc_ar_ready", {31'd0, axi_addr_r_ready_o}, 32'd1);
    check("conc_aw_ready", {31'd0, axi_addr_w_ready_o}, 32'd1);
    @(negedge clock);
    axi_addr_r_valid_i = 1'b0;
    axi_addr_w_valid_i = 1'b0;
    check("conc_ar_busy", {31'd0, axi_addr_r_ready_o}, 32'd0);
    check("conc_aw_busy", {31'd0, axi_addr_w_ready_o}, 32'd0);
    w_beat(32'h0BAD_F00D, 4'hF, 1'b1);
    b_check(2'b00, 5);
    wait_rvalid();
    check("conc_rd_data", axi_r_data_o, 32'hDEAD_BEEF);
    axi_r_ready_i = 1'b1;
    @(negedge clock);
    axi_r_ready_i = 1'b0;
    rd_single("conc_wr_back", 32'h8000_0028, 32'h0BAD_F00D, 2'b00);

    // Reset during beat 2 of 4
    axi_r_ready_i = 1'b1;
    ar_req(32'h8000_0000, 8'd3);
    wait_rvalid();
    check("rst_burst_b0", axi_r_data_o, 32'hA000_0000);
    @(negedge clock);
    check("rst_burst_b1", axi_r_data_o, 32'hA000_0001);
    axi_r_ready_i = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_r_valid", {31'd0, axi_r_valid_o}, 32'd0);
    check("rst_mid_r_last", {31'd0, axi_r_last_o}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst_after_ar_ready", {31'd0, axi_addr_r_ready_o}, 32'd1);
    check("rst_after_r_valid", {31'd0, axi_r_valid_o}, 32'd0);
    rd_single("rst_mem_kept", 32'h8000_0004, 32'hA000_0001, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 responder (slave) modelling an on-chip SRAM at the far end of the Xbar, opposite the core's AXI master controller.
- Accepts INCR read and write bursts and returns data and responses with a programmable read latency.
- Provides a single-port byte-addressable word array used as the SOC memory target in simulation.
- Read and write channels run as independent state machines, so one read and one write can be outstanding at the same time.

Parameters:
- ADDR_LEN, 32, address width.
- DATA_LEN, 32, data width; fixed at 32, giving 4 strobe bits.
- MEM_WORDS, 1024, number of 32-bit words in the array.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LATENCY, 2, cycles from AR handshake to first R beat. Minimum is 1.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- axi_addr_r_addr_i  in  ADDR_LEN  read burst start address
- axi_addr_r_valid_i  in  1  AR valid
- axi_addr_r_ready_o  out  1  AR ready
- axi_addr_r_len_i  in  8  beats minus 1
- axi_addr_r_size_i  in  3  log2 of bytes per beat; 0 to 2 are legal
- axi_r_data_o  out  DATA_LEN  read data
- axi_r_resp_o  out  2  read response: 00 OKAY, 10 SLVERR
- axi_r_valid_o  out  1  R valid
- axi_r_last_o  out  1  final beat of the burst
- axi_r_ready_i  in  1  R ready
- axi_addr_w_addr_i  in  ADDR_LEN  write burst start address
- axi_addr_w_valid_i  in  1  AW valid
- axi_addr_w_ready_o  out  1  AW ready
- axi_addr_w_len_i  in  8  beats minus 1
- axi_addr_w_size_i  in  3  log2 of bytes per beat
- axi_w_data_i  in  DATA_LEN  write data
- axi_w_strb_i  in  4  byte strobes
- axi_w_valid_i  in  1  W valid
- axi_w_ready_o  out  1  W ready
- axi_w_last_i  in  1  W last
- axi_bkwd_resp_o  out  2  B response
- axi_bkwd_valid_o  out  1  B valid
- axi_bkwd_ready_i  in  1  B ready

Behaviour:
- Reset clears every valid, ready, last and resp output to 0, puts both FSMs in IDLE and zeroes the counters. Memory contents are not reset.
- Read FSM, states R_IDLE, R_WAIT, R_DATA:
  - R_IDLE: axi_addr_r_ready_o=1. An AR handshake latches addr, len and size, loads the delay counter with RD_LATENCY-1, and moves to R_WAIT.
  - R_WAIT: the counter decrements each cycle. When it reaches 0, the FSM registers the word at the current address into r_data, asserts r_valid, and moves to R_DATA. With RD_LATENCY=1, r_valid rises on the cycle after the AR handshake.
  - R_DATA: on r_valid & r_ready, beat_cnt increments and addr advances by (1<<size) modulo 2^ADDR_LEN. The next word is presented in the following cycle with no bubble.
  - r_last=1 when beat_cnt==len.
  - The handshake on the last beat returns the FSM to R_IDLE, where ar_ready is 1 in the next cycle.
  - While r_ready=0, r_data, r_resp and r_last hold stable.
- Address decoding:
  - The word index is (addr-BASE_ADDR)>>2. The byte lane is ignored: a full word is always returned.
  - An address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) is decoded per beat. A read returns data 0 with resp 10. A write beat is dropped and the sticky error flag is set.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: axi_addr_w_ready_o=1. An AW handshake latches addr and size, clears the error flag, and moves to W_DATA.
  - W_DATA: w_ready=1. On each W handshake, the bytes whose strobe is set are written at the current address in the same clock edge, and addr advances by (1<<size).
  - The W handshake with w_last=1 moves to W_RESP.
  - The beat count is not checked against len, and a length mismatch is not flagged.
  - W_RESP: b_valid=1, with b_resp=10 if the error flag is set, otherwise 00. The B handshake returns the FSM to W_IDLE.
- A write that completes on the same edge the read FSM samples the same word: the read returns the old data, because the array is read before the write lands.
- Reset asserted mid-burst aborts both FSMs on the next edge and drives all valids low. Memory already written stays written.

Test Plan:
- Single read, RD_LATENCY=2: preload 0x80000010=0xDEADBEEF, AR addr 0x80000010 len 0 size 2 at cycle t → r_valid, r_last at t+2, data 0xDEADBEEF, resp 00.
- 4-beat read burst with r_ready toggling 1,0,1,0,…: AR 0x80000000 len 3 → data words 0..3 in order, data held stable during stalls, r_last only on the 4th beat, ar_ready back to 1 the cycle after the last handshake.
- Write burst: AW 0x80000020 len 1, W 0x11223344 strb 0xF, then W 0xAABBCCDD strb 0x3 last → b_valid with resp 00. Read-back gives 0x11223344 and (old upper bytes)|0xCCDD.
- Out-of-range: AR 0x7FFFFFFC → resp 10, data 0. AW 0x90000000 → memory unchanged, b_resp 10.
- Concurrent: AR and AW in the same cycle → both accepted, read and write complete independently. B is held until bready is raised 5 cycles later.
- Reset during R_DATA beat 2 of 4 → r_valid=0 on the next edge, ar_ready=1 after reset deasserts.
